// File: rtl/gmii_rx_src.sv
// gmii_rx_src: PHY-side GMII/MII frame source (preamble, SFD, data, pad, FCS, IFG) for MAC loopback/BIST.
// Optional error injection (inj_req/inj_idx ports) is built when GMII_RX_SRC_ERR_INJ_EN is defined.
module gmii_rx_src #(
  parameter int PRE_LEN = 7,
  parameter int MIN_LEN = 60,
  parameter int IFG_LEN = 12
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        cfg_mii_mode,
  input  logic        cfg_pad_en,
  input  logic        cfg_fcs_en,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
`ifdef GMII_RX_SRC_ERR_INJ_EN
  input  logic        inj_req,
  input  logic [13:0] inj_idx,
`endif
  output logic [7:0]  gmii_rxd,
  output logic        gmii_rx_dv,
  output logic        gmii_rx_er,
  output logic        gmii_crs,
  output logic        gmii_col,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun,
  output logic [13:0] byte_cnt
);
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, DRAIN, IFG} state_t;
  state_t      state_q, state_d, st;
  logic [7:0]  cnt_q, cnt_d;
  logic        ph_q, ph_d;
  logic        mii_q, mii_d, pad_q, pad_d, fcs_q, fcs_d;
  logic [7:0]  data_q, data_d;
  logic        last_q, last_d, bad_q, bad_d, hit_q, hit_d;
  logic [31:0] crc_q, crc_d, fcs_w;
  logic [13:0] byte_cnt_q, byte_cnt_d, cnt_inc;
  logic [7:0]  rxd_q, rxd_d, byte_v;
  logic        dv_q, dv_d, er_q, er_d, fd_q, fd_d, und_q, und_d;
  logic        start, mii, slot_end, first, hit_now;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction

`ifdef GMII_RX_SRC_ERR_INJ_EN
  logic        inj_q;
  logic [13:0] inj_idx_q;
  // capture the injection request together with the frame start
  always_ff @(posedge rx_clk or negedge rst_n)
    if (!rst_n) begin
      inj_q     <= 1'b0;
      inj_idx_q <= '0;
    end else if (start) begin
      inj_q     <= inj_req;
      inj_idx_q <= inj_idx;
    end
  assign hit_now = inj_q && byte_cnt_q == inj_idx_q;
`else
  assign hit_now = 1'b0;
`endif

  // The IDLE exit cycle already produces the first preamble slot, so it runs as PRE with the live cfg.
  assign start    = state_q == IDLE && s_valid;
  assign st       = start ? PRE : state_q;
  assign mii      = state_q == IDLE ? cfg_mii_mode : mii_q;
  assign slot_end = !mii || ph_q;
  assign first    = !ph_q;
  assign fcs_w    = ~crc_q;
  assign cnt_inc  = &byte_cnt_q ? byte_cnt_q : byte_cnt_q + 14'd1;
  assign mii_d    = start ? cfg_mii_mode : mii_q;
  assign pad_d    = start ? cfg_pad_en : pad_q;
  assign fcs_d    = start ? cfg_fcs_en : fcs_q;

  // next state, slot byte, CRC/count update and the values for the registered outputs
  always_comb begin
    state_d    = st;
    cnt_d      = cnt_q;
    ph_d       = 1'b0;
    crc_d      = start ? '1 : crc_q;
    byte_cnt_d = start ? '0 : byte_cnt_q;
    data_d     = data_q;
    last_d     = last_q;
    bad_d      = bad_q;
    hit_d      = hit_q;
    byte_v     = 8'h00;
    dv_d       = 1'b0;
    er_d       = 1'b0;
    und_d      = 1'b0;
    s_ready    = 1'b0;
    case (st)
      PRE: begin
        byte_v = 8'h55;
        dv_d   = 1'b1;
        ph_d   = mii & ~ph_q;
        if (slot_end) begin
          cnt_d   = cnt_q == 8'(PRE_LEN - 1) ? '0 : cnt_q + 8'd1;
          state_d = cnt_q == 8'(PRE_LEN - 1) ? SFD : PRE;
        end
      end
      SFD: begin
        byte_v = 8'hD5;
        dv_d   = 1'b1;
        ph_d   = mii & ~ph_q;
        if (slot_end) state_d = DATA;
      end
      DATA: begin
        s_ready = first;
        bad_d   = first ? !s_valid : bad_q;
        last_d  = first ? s_last : last_q;
        data_d  = first ? s_data : data_q;
        hit_d   = first ? hit_now : hit_q;
        byte_v  = bad_d ? 8'h00 : data_d;
        dv_d    = 1'b1;
        er_d    = bad_d | hit_d;
        und_d   = first & !s_valid;
        ph_d    = mii & ~ph_q;
        if (first && s_valid) begin
          crc_d      = crc_upd(crc_q, s_data);
          byte_cnt_d = cnt_inc;
        end
        if (slot_end)
          state_d = bad_d ? DRAIN : !last_d ? DATA :
                    (pad_q && byte_cnt_d < 14'(MIN_LEN)) ? PAD : fcs_q ? FCS : IFG;
      end
      PAD: begin
        hit_d = first ? hit_now : hit_q;
        er_d  = hit_d;
        dv_d  = 1'b1;
        ph_d  = mii & ~ph_q;
        if (first) begin
          crc_d      = crc_upd(crc_q, 8'h00);
          byte_cnt_d = cnt_inc;
        end
        if (slot_end && byte_cnt_d >= 14'(MIN_LEN)) state_d = fcs_q ? FCS : IFG;
      end
      FCS: begin
        byte_v = fcs_w[{cnt_q[1:0], 3'b000} +: 8];
        dv_d   = 1'b1;
        ph_d   = mii & ~ph_q;
        if (slot_end) begin
          cnt_d   = cnt_q == 8'd3 ? '0 : cnt_q + 8'd1;
          state_d = cnt_q == 8'd3 ? IFG : FCS;
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_d = IFG;
      end
      IFG: begin
        ph_d = mii & ~ph_q;
        if (slot_end) begin
          cnt_d   = cnt_q == 8'(IFG_LEN - 1) ? '0 : cnt_q + 8'd1;
          state_d = cnt_q == 8'(IFG_LEN - 1) ? IDLE : IFG;
        end
      end
      default: ;
    endcase
    rxd_d = mii ? {4'h0, ph_q ? byte_v[7:4] : byte_v[3:0]} : byte_v;
    fd_d  = state_d == IFG && (st == DATA || st == PAD || st == FCS);
  end

  // state, datapath and registered PHY outputs; reset drops dv immediately
  always_ff @(posedge rx_clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ph_q       <= 1'b0;
      mii_q      <= 1'b0;
      pad_q      <= 1'b0;
      fcs_q      <= 1'b0;
      data_q     <= '0;
      last_q     <= 1'b0;
      bad_q      <= 1'b0;
      hit_q      <= 1'b0;
      crc_q      <= '1;
      byte_cnt_q <= '0;
      rxd_q      <= '0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      fd_q       <= 1'b0;
      und_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ph_q       <= ph_d;
      mii_q      <= mii_d;
      pad_q      <= pad_d;
      fcs_q      <= fcs_d;
      data_q     <= data_d;
      last_q     <= last_d;
      bad_q      <= bad_d;
      hit_q      <= hit_d;
      crc_q      <= crc_d;
      byte_cnt_q <= byte_cnt_d;
      rxd_q      <= rxd_d;
      dv_q       <= dv_d;
      er_q       <= er_d;
      fd_q       <= fd_d;
      und_q      <= und_d;
    end

  assign gmii_rxd   = rxd_q;
  assign gmii_rx_dv = dv_q;
  assign gmii_rx_er = er_q;
  assign gmii_crs   = dv_q;
  assign gmii_col   = 1'b0;
  assign busy       = state_q != IDLE;
  assign frame_done = fd_q;
  assign underrun   = und_q;
  assign byte_cnt   = byte_cnt_q;
endmodule

// File: tb/tb_gmii_rx_src.sv
// tb_gmii_rx_src: directed bench for gmii_rx_src (GMII/MII framing, pad, FCS, underrun, IFG, reset).
module tb_gmii_rx_src;
  logic        rx_clk = 1'b0, rst_n = 1'b0;
  logic        cfg_mii_mode = 1'b0, cfg_pad_en = 1'b0, cfg_fcs_en = 1'b0;
  logic        s_valid = 1'b0, s_last = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready, gmii_rx_dv, gmii_rx_er, gmii_crs, gmii_col, busy, frame_done, underrun;
  logic [7:0]  gmii_rxd;
  logic [13:0] byte_cnt;
`ifdef GMII_RX_SRC_ERR_INJ_EN
  logic        inj_req = 1'b0;
  logic [13:0] inj_idx = '0;
`endif

  gmii_rx_src dut (
    .rx_clk(rx_clk), .rst_n(rst_n),
    .cfg_mii_mode(cfg_mii_mode), .cfg_pad_en(cfg_pad_en), .cfg_fcs_en(cfg_fcs_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
`ifdef GMII_RX_SRC_ERR_INJ_EN
    .inj_req(inj_req), .inj_idx(inj_idx),
`endif
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .gmii_crs(gmii_crs), .gmii_col(gmii_col), .busy(busy),
    .frame_done(frame_done), .underrun(underrun), .byte_cnt(byte_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  typedef struct packed {logic er; logic dv; logic [7:0] rxd;} smp_t;
  smp_t       cap[$];
  int         fd_n, und_n, rdy_n;
  logic       clr = 1'b0;
  int         n_cmp = 0, n_err = 0, tmo = 0;
  logic [7:0] fb[$], fr[$], ref_b[$];
  int         fs, flen, fnext, er_n, er_at, bad;

  always @(negedge rx_clk)
    if (clr) begin
      cap.delete();
      fd_n  <= 0;
      und_n <= 0;
      rdy_n <= 0;
    end else begin
      cap.push_back({gmii_rx_er, gmii_rx_dv, gmii_rxd});
      fd_n  <= fd_n + int'(frame_done);
      und_n <= und_n + int'(underrun);
      rdy_n <= rdy_n + int'(s_ready);
    end

  function automatic logic [31:0] crc_ref(input logic [7:0] d[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    logic        f;
    foreach (d[i])
      for (int j = 0; j < 8; j++) begin
        f = c[0] ^ d[i][j];
        c = {1'b0, c[31:1]} ^ (f ? 32'hEDB88320 : 32'h0);
      end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    @(posedge rx_clk);
    clr = 1'b1;
    @(negedge rx_clk);
    #1 clr = 1'b0;
  endtask

  task automatic send(input logic [7:0] b[$], input int drop_at, input bit hold);
    int w;
    for (int i = 0; i < b.size(); i++) begin
      @(negedge rx_clk);
      if (i == drop_at) begin
        s_valid = 1'b0;
        @(negedge rx_clk);
      end
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = i == b.size() - 1;
      #1 w = 0;
      while (!s_ready && w < 2000) begin
        @(negedge rx_clk);
        #1 w++;
      end
      if (w >= 2000) tmo++;
    end
    if (!hold) begin
      @(negedge rx_clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    do begin
      @(negedge rx_clk);
      w++;
    end while (busy && w < 5000);
    if (w >= 5000) tmo++;
    repeat (3) @(negedge rx_clk);
  endtask

  task automatic extract(input int from, input bit mii);
    int i = from;
    fb.delete();
    flen = 0;
    while (i < cap.size() && !cap[i].dv) i++;
    fs = i;
    while (i < cap.size() && cap[i].dv) begin
      flen++;
      i++;
    end
    fnext = i;
    er_n  = 0;
    er_at = -1;
    foreach (cap[k])
      if (cap[k].er) begin
        if (er_at < 0) er_at = k;
        er_n++;
      end
    for (int k = fs; k < fs + flen; k += (mii ? 2 : 1))
      fb.push_back(mii ? {cap[k+1].rxd[3:0], cap[k].rxd[3:0]} : cap[k].rxd);
  endtask

  function automatic logic [31:0] fcs_rx();
    int n = fb.size();
    return {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
  endfunction

  function automatic int pre_bad();
    int e = (fb[7] !== 8'hD5) ? 1 : 0;
    for (int i = 0; i < 7; i++) if (fb[i] !== 8'h55) e++;
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge rx_clk);
    check("reset outputs", {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_crs, gmii_col, busy, frame_done, underrun}, 0);
    check("reset byte_cnt", 32'(byte_cnt), 0);
    check("reset s_ready", 32'(s_ready), 0);
    rst_n = 1'b1;

    // GMII, pad+fcs, 60 bytes 0x00..0x3B
    cfg_pad_en = 1'b1;
    cfg_fcs_en = 1'b1;
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'(i));
    clear();
    send(fr, -1, 0);
    wait_idle();
    extract(0, 0);
    check("t1 first preamble latency", fs, 1);
    check("t1 dv length", flen, 72);
    check("t1 preamble/sfd", pre_bad(), 0);
    bad = 0;
    for (int i = 0; i < 60; i++) if (fb[8+i] !== fr[i]) bad++;
    check("t1 data bytes", bad, 0);
    check("t1 fcs", fcs_rx(), ~crc_ref(fr));
    check("t1 frame_done", fd_n, 1);
    check("t1 er count", er_n, 0);
    check("t1 byte_cnt", 32'(byte_cnt), 60);

    // GMII, no pad, "123456789" gives the standard check value
    cfg_pad_en = 1'b0;
    fr.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'h31 + 8'(i));
    clear();
    send(fr, -1, 0);
    wait_idle();
    extract(0, 0);
    check("t2 dv length", flen, 21);
    check("t2 fcs bytes", fcs_rx(), 32'hCBF43926);
    check("t2 byte_cnt", 32'(byte_cnt), 9);

    // MII, padded 1-byte frame; cfg changes mid-frame must be ignored
    cfg_mii_mode = 1'b1;
    cfg_pad_en   = 1'b1;
    fr.delete();
    fr.push_back(8'hAB);
    clear();
    send(fr, -1, 0);
    cfg_mii_mode = 1'b0;
    cfg_pad_en   = 1'b0;
    cfg_fcs_en   = 1'b0;
    wait_idle();
    extract(0, 1);
    check("t3 first preamble latency", fs, 1);
    check("t3 dv length", flen, 144);
    check("t3 low nibble first", 32'(cap[fs+16].rxd), 32'h0B);
    check("t3 high nibble second", 32'(cap[fs+17].rxd), 32'h0A);
    bad = 0;
    for (int k = fs; k < fs + flen; k++) if (cap[k].rxd[7:4] !== 4'h0) bad++;
    check("t3 upper nibble zero", bad, 0);
    check("t3 s_ready pulses", rdy_n, 1);
    ref_b = fr;
    for (int i = 0; i < 59; i++) ref_b.push_back(8'h00);
    bad = 0;
    for (int i = 0; i < 59; i++) if (fb[9+i] !== 8'h00) bad++;
    check("t3 pad bytes", bad, 0);
    check("t3 fcs", fcs_rx(), ~crc_ref(ref_b));
    check("t3 byte_cnt", 32'(byte_cnt), 60);
    check("t3 frame_done", fd_n, 1);

    // GMII underrun after 20 of 64 bytes
    cfg_pad_en = 1'b1;
    cfg_fcs_en = 1'b1;
    fr.delete();
    for (int i = 0; i < 64; i++) fr.push_back(8'(i + 100));
    clear();
    send(fr, 20, 0);
    wait_idle();
    extract(0, 0);
    check("t4 underrun pulses", und_n, 1);
    check("t4 er count", er_n, 1);
    check("t4 er position", er_at - fs, 28);
    check("t4 er rxd", 32'(cap[er_at].rxd), 0);
    check("t4 dv length", flen, 29);
    check("t4 frame_done", fd_n, 0);
    check("t4 byte_cnt", 32'(byte_cnt), 20);

    // two back-to-back 10-byte frames
    cfg_pad_en = 1'b0;
    fr.delete();
    for (int i = 0; i < 10; i++) fr.push_back(8'(i * 7));
    clear();
    send(fr, -1, 1);
    send(fr, -1, 0);
    wait_idle();
    extract(0, 0);
    check("t5 frame A length", flen, 22);
    check("t5 frame A fcs", fcs_rx(), ~crc_ref(fr));
    bad = fnext;
    extract(fnext, 0);
    check("t5 ifg gap", fs - bad, 12);
    check("t5 frame B length", flen, 22);
    check("t5 frame_done", fd_n, 2);

    // asynchronous reset in the middle of a frame
    @(negedge rx_clk);
    s_valid = 1'b1;
    s_data  = 8'h11;
    s_last  = 1'b0;
    bad = 0;
    while (!gmii_rx_dv && bad < 100) begin
      @(negedge rx_clk);
      bad++;
    end
    if (bad >= 100) tmo++;
    #2 rst_n = 1'b0;
    #1 check("async reset dv", {gmii_rx_dv, gmii_crs, busy}, 0);
    s_valid = 1'b0;
    @(negedge rx_clk);
    rst_n = 1'b1;

`ifdef GMII_RX_SRC_ERR_INJ_EN
    cfg_pad_en = 1'b1;
    inj_req    = 1'b1;
    inj_idx    = 14'd5;
    fr.delete();
    for (int i = 0; i < 60; i++) fr.push_back(8'(i));
    clear();
    send(fr, -1, 0);
    inj_req = 1'b0;
    wait_idle();
    extract(0, 0);
    check("inj er count", er_n, 1);
    check("inj er position", er_at - fs, 13);
    check("inj fcs", fcs_rx(), ~crc_ref(fr));
    check("inj frame_done", fd_n, 1);
`endif

    check("timeouts", tmo, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
